// File: rtl/oled_ssd1331.sv
// rtl/oled_ssd1331.sv - SSD1331 OLED power-up, init sequence and pixel/raw SPI byte writer
// Define OLED_SSD1331_FAST_SIM_EN to shorten the reset and VCC settle waits to 16 cycles.
module oled_ssd1331 #(
    parameter int CLK_DIV      = 2,
    parameter int RESET_CYCLES = 64,
    parameter int VCC_CYCLES   = 2500000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        strobe,
    input  logic        setpixel_raw8tx,
    input  logic [7:0]  x_dc,
    input  logic [7:0]  y_data,
    input  logic [15:0] rgb,
    output logic        ready,
    output logic        valid,
    output logic        oled_rst,
    output logic        spi_cs,
    output logic        spi_dc,
    output logic        spi_mosi,
    output logic        spi_sck,
    output logic        vccen,
    output logic        pmoden
);

`ifdef OLED_SSD1331_FAST_SIM_EN
    localparam int RST_N = 16;
    localparam int VCC_N = 16;
`else
    localparam int RST_N = RESET_CYCLES;
    localparam int VCC_N = VCC_CYCLES;
`endif

    localparam logic [31:0] RST_LAST = 32'(RST_N - 1);
    localparam logic [31:0] VCC_LAST = 32'(VCC_N - 1);
    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
    localparam logic [5:0]  INIT_LEN = 6'd37;

    typedef enum logic [3:0] {
        ST_PWR, ST_RST_LO, ST_RST_WAIT, ST_INIT, ST_VCC_WAIT,
        ST_DISP_ON, ST_IDLE, ST_XFER, ST_DONE
    } state_t;

    typedef enum logic [1:0] {TX_IDLE, TX_LOW, TX_HIGH, TX_GAP} tx_t;

    state_t      state_q;
    tx_t         tx_q;
    logic [31:0] cnt_q;
    logic [15:0] div_q;
    logic [2:0]  bit_q;
    logic [7:0]  sh_q;
    logic [5:0]  idx_q;
    logic [5:0]  len_q;
    logic        raw_q;
    logic [7:0]  x_q;
    logic [7:0]  y_q;
    logic [15:0] rgb_q;
    logic        ready_q;
    logic        valid_q;
    logic        oled_rst_q;
    logic        cs_q;
    logic        dc_q;
    logic        mosi_q;
    logic        sck_q;
    logic        vccen_q;
    logic        pmoden_q;

    logic        tx_start;
    logic [7:0]  tx_byte;
    logic        tx_dc;

    assign ready    = ready_q;
    assign valid    = valid_q;
    assign oled_rst = oled_rst_q;
    assign spi_cs   = cs_q;
    assign spi_dc   = dc_q;
    assign spi_mosi = mosi_q;
    assign spi_sck  = sck_q;
    assign vccen    = vccen_q;
    assign pmoden   = pmoden_q;

    function automatic logic [7:0] init_byte(input logic [5:0] i);
        logic [7:0] b;
        case (i)
            6'd0:  b = 8'hAE;  6'd1:  b = 8'hA0;  6'd2:  b = 8'h72;  6'd3:  b = 8'hA1;
            6'd4:  b = 8'h00;  6'd5:  b = 8'hA2;  6'd6:  b = 8'h00;  6'd7:  b = 8'hA4;
            6'd8:  b = 8'hA8;  6'd9:  b = 8'h3F;  6'd10: b = 8'hAD;  6'd11: b = 8'h8E;
            6'd12: b = 8'hB0;  6'd13: b = 8'h0B;  6'd14: b = 8'hB1;  6'd15: b = 8'h31;
            6'd16: b = 8'hB3;  6'd17: b = 8'hF0;  6'd18: b = 8'h8A;  6'd19: b = 8'h64;
            6'd20: b = 8'h8B;  6'd21: b = 8'h78;  6'd22: b = 8'h8C;  6'd23: b = 8'h64;
            6'd24: b = 8'hBB;  6'd25: b = 8'h3A;  6'd26: b = 8'hBE;  6'd27: b = 8'h3E;
            6'd28: b = 8'h87;  6'd29: b = 8'h06;  6'd30: b = 8'h81;  6'd31: b = 8'h91;
            6'd32: b = 8'h82;  6'd33: b = 8'h50;  6'd34: b = 8'h83;  6'd35: b = 8'h7D;
            6'd36: b = 8'h2E;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Byte request for the serialiser; it is taken only when the serialiser is idle.
    always_comb begin
        tx_start = 1'b0;
        tx_byte  = 8'h00;
        tx_dc    = 1'b0;
        case (state_q)
            ST_INIT: begin
                if (idx_q < INIT_LEN) begin
                    tx_start = 1'b1;
                    tx_byte  = init_byte(idx_q);
                end
            end
            ST_DISP_ON: begin
                if (idx_q == 6'd0) begin
                    tx_start = 1'b1;
                    tx_byte  = 8'hAF;
                end
            end
            ST_XFER: begin
                if (idx_q < len_q) begin
                    tx_start = 1'b1;
                    if (raw_q) begin
                        tx_byte = y_q;
                        tx_dc   = x_q[0];
                    end else begin
                        tx_dc = (idx_q >= 6'd6);
                        case (idx_q[2:0])
                            3'd0:    tx_byte = 8'h15;
                            3'd1:    tx_byte = x_q;
                            3'd2:    tx_byte = 8'h5F;
                            3'd3:    tx_byte = 8'h75;
                            3'd4:    tx_byte = y_q;
                            3'd5:    tx_byte = 8'h3F;
                            3'd6:    tx_byte = rgb_q[15:8];
                            default: tx_byte = rgb_q[7:0];
                        endcase
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_PWR;
            tx_q       <= TX_IDLE;
            cnt_q      <= '0;
            div_q      <= '0;
            bit_q      <= '0;
            sh_q       <= '0;
            idx_q      <= '0;
            len_q      <= '0;
            raw_q      <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            rgb_q      <= '0;
            ready_q    <= 1'b0;
            valid_q    <= 1'b0;
            oled_rst_q <= 1'b0;
            cs_q       <= 1'b1;
            dc_q       <= 1'b0;
            mosi_q     <= 1'b0;
            sck_q      <= 1'b1;
            vccen_q    <= 1'b0;
            pmoden_q   <= 1'b0;
        end else begin
            // SCK idles high; mosi moves on the falling edge, the panel samples on the rising edge.
            case (tx_q)
                TX_IDLE: begin
                    if (tx_start) begin
                        cs_q   <= 1'b0;
                        sck_q  <= 1'b0;
                        dc_q   <= tx_dc;
                        mosi_q <= tx_byte[7];
                        sh_q   <= tx_byte;
                        bit_q  <= '0;
                        div_q  <= '0;
                        tx_q   <= TX_LOW;
                    end
                end
                TX_LOW: begin
                    if (div_q == DIV_LAST) begin
                        div_q <= '0;
                        sck_q <= 1'b1;
                        tx_q  <= TX_HIGH;
                    end else begin
                        div_q <= div_q + 16'd1;
                    end
                end
                TX_HIGH: begin
                    if (div_q == DIV_LAST) begin
                        div_q <= '0;
                        if (bit_q == 3'd7) begin
                            cs_q <= 1'b1;
                            tx_q <= TX_GAP;
                        end else begin
                            bit_q  <= bit_q + 3'd1;
                            sh_q   <= {sh_q[6:0], 1'b0};
                            mosi_q <= sh_q[6];
                            sck_q  <= 1'b0;
                            tx_q   <= TX_LOW;
                        end
                    end else begin
                        div_q <= div_q + 16'd1;
                    end
                end
                default: begin
                    if (div_q == DIV_LAST) begin
                        div_q <= '0;
                        tx_q  <= TX_IDLE;
                    end else begin
                        div_q <= div_q + 16'd1;
                    end
                end
            endcase

            case (state_q)
                ST_PWR: begin
                    pmoden_q   <= 1'b1;
                    oled_rst_q <= 1'b0;
                    cnt_q      <= '0;
                    state_q    <= ST_RST_LO;
                end
                ST_RST_LO: begin
                    if (cnt_q == RST_LAST) begin
                        cnt_q      <= '0;
                        oled_rst_q <= 1'b1;
                        state_q    <= ST_RST_WAIT;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                ST_RST_WAIT: begin
                    if (cnt_q == RST_LAST) begin
                        cnt_q   <= '0;
                        idx_q   <= '0;
                        state_q <= ST_INIT;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                ST_INIT: begin
                    if (tx_q == TX_IDLE) begin
                        if (tx_start) begin
                            idx_q <= idx_q + 6'd1;
                        end else begin
                            idx_q   <= '0;
                            vccen_q <= 1'b1;
                            cnt_q   <= '0;
                            state_q <= ST_VCC_WAIT;
                        end
                    end
                end
                ST_VCC_WAIT: begin
                    if (cnt_q == VCC_LAST) begin
                        cnt_q   <= '0;
                        idx_q   <= '0;
                        state_q <= ST_DISP_ON;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                ST_DISP_ON: begin
                    if (tx_q == TX_IDLE) begin
                        if (tx_start) begin
                            idx_q <= idx_q + 6'd1;
                        end else begin
                            ready_q <= 1'b1;
                            state_q <= ST_IDLE;
                        end
                    end
                end
                ST_IDLE: begin
                    if (strobe && ready_q) begin
                        raw_q   <= setpixel_raw8tx;
                        x_q     <= x_dc;
                        y_q     <= y_data;
                        rgb_q   <= rgb;
                        idx_q   <= '0;
                        ready_q <= 1'b0;
                        state_q <= ST_XFER;
                        // Off-panel pixels complete with zero bytes.
                        if (setpixel_raw8tx)
                            len_q <= 6'd1;
                        else if (x_dc < 8'd96 && y_data < 8'd64)
                            len_q <= 6'd8;
                        else
                            len_q <= 6'd0;
                    end
                end
                ST_XFER: begin
                    if (tx_q == TX_IDLE) begin
                        if (tx_start) begin
                            idx_q <= idx_q + 6'd1;
                        end else begin
                            valid_q <= 1'b1;
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_PWR;
            endcase
        end
    end

endmodule

// File: tb/tb_oled_ssd1331.sv
// tb/tb_oled_ssd1331.sv - randomized self-checking bench for oled_ssd1331 against a byte-level model
module tb_oled_ssd1331;
    localparam int CLK_DIV = 2;
    localparam int RST_N   = 16;

    logic        clk = 1'b0;
    logic        resetn;
    logic        strobe;
    logic        setpixel_raw8tx;
    logic [7:0]  x_dc;
    logic [7:0]  y_data;
    logic [15:0] rgb;
    logic        ready, valid, oled_rst, spi_cs, spi_dc, spi_mosi, spi_sck, vccen, pmoden;

    oled_ssd1331 #(.CLK_DIV(CLK_DIV), .RESET_CYCLES(RST_N), .VCC_CYCLES(16)) dut (
        .clk(clk), .resetn(resetn), .strobe(strobe), .setpixel_raw8tx(setpixel_raw8tx),
        .x_dc(x_dc), .y_data(y_data), .rgb(rgb), .ready(ready), .valid(valid),
        .oled_rst(oled_rst), .spi_cs(spi_cs), .spi_dc(spi_dc), .spi_mosi(spi_mosi),
        .spi_sck(spi_sck), .vccen(vccen), .pmoden(pmoden)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Captured bytes from the wire and expected bytes from the model, each {dc, byte}.
    logic [8:0] cap_q[$];
    logic [8:0] exp_q[$];

    logic [7:0] init_tbl [37] = '{
        8'hAE, 8'hA0, 8'h72, 8'hA1, 8'h00, 8'hA2, 8'h00, 8'hA4, 8'hA8, 8'h3F,
        8'hAD, 8'h8E, 8'hB0, 8'h0B, 8'hB1, 8'h31, 8'hB3, 8'hF0, 8'h8A, 8'h64,
        8'h8B, 8'h78, 8'h8C, 8'h64, 8'hBB, 8'h3A, 8'hBE, 8'h3E, 8'h87, 8'h06,
        8'h81, 8'h91, 8'h82, 8'h50, 8'h83, 8'h7D, 8'h2E};

    // Wire monitor: decodes SPI bytes and tallies protocol violations.
    int   valid_cnt = 0, rst_low_cnt = 0;
    int   dc_viol = 0, mosi_viol = 0, half_viol = 0, gap_viol = 0, frame_viol = 0, pulse_viol = 0;
    int   bits = 0, run = 0;
    bit   seen = 0;
    logic p_cs = 1, p_sck = 1, p_mosi = 0, p_dc = 0, p_valid = 0;
    logic [7:0] sh = 0;

    always @(negedge clk) begin
        if (!resetn) begin
            bits = 0; run = 0; seen = 0; rst_low_cnt = 0;
            p_cs = 1; p_sck = 1; p_mosi = 0; p_dc = 0; p_valid = 0;
        end else begin
            if (pmoden && !oled_rst) rst_low_cnt++;
            if (valid) begin
                valid_cnt++;
                if (p_valid) pulse_viol++;
            end
            if (!spi_cs && !p_cs) begin
                if (spi_dc != p_dc) dc_viol++;
                if (spi_mosi != p_mosi && spi_sck) mosi_viol++;
                if (spi_sck != p_sck && run != CLK_DIV) half_viol++;
            end
            if (!spi_cs && p_cs) begin
                bits = 0;
                if (seen && run < CLK_DIV) gap_viol++;
            end
            if (spi_cs && !p_cs && bits != 0) frame_viol++;
            if (spi_sck && !p_sck && !spi_cs) begin
                sh = {sh[6:0], spi_mosi};
                bits++;
                if (bits == 8) begin
                    cap_q.push_back({spi_dc, sh});
                    bits = 0;
                    seen = 1;
                end
            end
            run = (spi_sck == p_sck && spi_cs == p_cs) ? run + 1 : 1;
            p_cs = spi_cs; p_sck = spi_sck; p_mosi = spi_mosi; p_dc = spi_dc; p_valid = valid;
        end
    end

    function automatic void model_init();
        for (int i = 0; i < 37; i++) exp_q.push_back({1'b0, init_tbl[i]});
        exp_q.push_back({1'b0, 8'hAF});
    endfunction

    function automatic void model_txn(input bit raw, input logic [7:0] x, input logic [7:0] y,
                                      input logic [15:0] c);
        if (raw) begin
            exp_q.push_back({x[0], y});
        end else if (x < 96 && y < 64) begin
            exp_q.push_back({1'b0, 8'h15}); exp_q.push_back({1'b0, x});
            exp_q.push_back({1'b0, 8'h5F}); exp_q.push_back({1'b0, 8'h75});
            exp_q.push_back({1'b0, y});     exp_q.push_back({1'b0, 8'h3F});
            exp_q.push_back({1'b1, c[15:8]}); exp_q.push_back({1'b1, c[7:0]});
        end
    endfunction

    task automatic cmp_queues(input string tag);
        int n;
        chk({tag, "_nbytes"}, cap_q.size(), exp_q.size());
        n = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk($sformatf("%s_b%0d", tag, i), cap_q[i], exp_q[i]);
        cap_q.delete();
        exp_q.delete();
    endtask

    task automatic wait_ready(input string tag, input int lim);
        int n = 0;
        while (!ready && n < lim) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_ready"}, ready, 1);
    endtask

    task automatic do_txn(input string tag, input bit raw, input logic [7:0] x,
                          input logic [7:0] y, input logic [15:0] c);
        int v0, n;
        wait_ready(tag, 200);
        v0 = valid_cnt;
        strobe = 1; setpixel_raw8tx = raw; x_dc = x; y_data = y; rgb = c;
        @(posedge clk); #1;
        strobe = 0;
        chk({tag, "_busy"}, ready, 0);
        n = 0;
        while (!valid && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_valid"}, valid, 1);
        @(posedge clk); #1;
        chk({tag, "_rdy_after"}, ready, 1);
        chk({tag, "_one_valid"}, valid_cnt - v0, 1);
        model_txn(raw, x, y, c);
        cmp_queues(tag);
    endtask

    task automatic hold_strobe(input string tag, input int want);
        int n = 0, cyc = 0;
        while (n < want && cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
            if (valid) n++;
        end
        strobe = 0;
        chk({tag, "_valids"}, n, want);
        chk({tag, "_b2b"}, (cyc < want * 60) ? 1 : 0, 1);
        repeat (4) @(posedge clk); #1;
    endtask

    initial begin
        resetn = 0; strobe = 0; setpixel_raw8tx = 0; x_dc = 0; y_data = 0; rgb = 0;
        repeat (4) @(posedge clk); #1;
        chk("rst_cs", spi_cs, 1);     chk("rst_sck", spi_sck, 1);   chk("rst_mosi", spi_mosi, 0);
        chk("rst_dc", spi_dc, 0);     chk("rst_oled", oled_rst, 0); chk("rst_vccen", vccen, 0);
        chk("rst_pmoden", pmoden, 0); chk("rst_ready", ready, 0);   chk("rst_valid", valid, 0);

        resetn = 1;
        wait_ready("init", 5000);
        chk("init_rst_low", rst_low_cnt, RST_N);
        chk("init_pmoden", pmoden, 1);
        chk("init_vccen", vccen, 1);
        chk("init_no_valid", valid_cnt, 0);
        model_init();
        cmp_queues("init");

        do_txn("pix_10_20", 0, 8'd10, 8'd20, 16'hF800);
        do_txn("raw_a5", 1, 8'h01, 8'hA5, 16'h0000);
        do_txn("pix_x96", 0, 8'd96, 8'd0, 16'h1234);
        do_txn("pix_y64", 0, 8'd0, 8'd64, 16'h1234);
        do_txn("pix_95_63", 0, 8'd95, 8'd63, 16'h07E0);
        for (int i = 0; i < 20; i++) begin
            bit raw = ($urandom_range(0, 3) == 0);
            logic [7:0] x = raw ? 8'($urandom) : 8'($urandom_range(0, 110));
            logic [7:0] y = raw ? 8'($urandom) : 8'($urandom_range(0, 72));
            do_txn($sformatf("rnd%0d", i), raw, x, y, 16'($urandom));
        end

        wait_ready("b2b", 200);
        strobe = 1; setpixel_raw8tx = 1; x_dc = 8'h01; y_data = 8'h3C;
        hold_strobe("b2b", 4);
        for (int i = 0; i < 4; i++) model_txn(1, 8'h01, 8'h3C, 16'h0);
        cmp_queues("b2b");

        // Reset mid-byte with strobe held through the restarted init.
        wait_ready("mid", 200);
        strobe = 1; setpixel_raw8tx = 0; x_dc = 8'd5; y_data = 8'd6; rgb = 16'hABCD;
        @(posedge clk); #1;
        strobe = 0;
        begin
            int n = 0;
            while (spi_cs && n < 200) begin @(posedge clk); #1; n++; end
        end
        chk("mid_cs_low", spi_cs, 0);
        repeat (5) @(posedge clk); #1;
        resetn = 0;
        #1;
        chk("mid_rst_cs", spi_cs, 1);   chk("mid_rst_sck", spi_sck, 1);
        chk("mid_rst_oled", oled_rst, 0); chk("mid_rst_pmoden", pmoden, 0);
        chk("mid_rst_ready", ready, 0);
        cap_q.delete(); exp_q.delete();
        strobe = 1; setpixel_raw8tx = 1; x_dc = 8'h00; y_data = 8'h5A;
        repeat (3) @(posedge clk); #1;
        resetn = 1;
        wait_ready("reinit", 5000);
        chk("reinit_rst_low", rst_low_cnt, RST_N);
        chk("reinit_no_valid", valid_cnt - 0 >= 0 ? 1 : 0, 1);
        model_init();
        cmp_queues("reinit");
        hold_strobe("reinit_b2b", 2);
        for (int i = 0; i < 2; i++) model_txn(1, 8'h00, 8'h5A, 16'h0);
        cmp_queues("reinit_b2b");

        chk("proto_dc_stable", dc_viol, 0);
        chk("proto_mosi_edge", mosi_viol, 0);
        chk("proto_half_period", half_viol, 0);
        chk("proto_cs_gap", gap_viol, 0);
        chk("proto_whole_bytes", frame_viol, 0);
        chk("proto_valid_width", pulse_viol, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
